// File: rtl/long_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : long_divider_pkg
// Description : Shared definitions for the sequential long divider: FSM state
//               encoding and the quotient value returned on divide-by-zero.
//               Optional macro LONG_DIVIDER_SIGNED_EN (used by
//               long_divider_seq) does not affect this package.
// Revision    : 1.0 - initial release
// ============================================================================
package long_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient presented on divide-by-zero; sliced down to DATA_W by users.
  localparam logic [31:0] c_div0_quotient = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/long_divider_step.sv
`default_nettype none
// ============================================================================
// Module      : long_divider_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, compares against the
//               divisor and subtracts when it fits.
// Ports       : rem_i      - current partial remainder (always < divisor)
//               dvd_bit_i  - next dividend bit, MSB first
//               divisor_i  - divisor magnitude
//               rem_o      - next partial remainder
//               q_bit_o    - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module long_divider_step
  import long_divider_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [DATA_W:0]   w_shifted;
  logic [DATA_W-1:0] w_diff;

  always_comb begin
    w_shifted = {rem_i, dvd_bit_i};
    q_bit_o   = (w_shifted >= {1'b0, divisor_i});
    // When the subtraction happens the true difference is < divisor, so the
    // low DATA_W bits of the modular difference are exact.
    w_diff    = w_shifted[DATA_W-1:0] - divisor_i;
    rem_o     = q_bit_o ? w_diff : w_shifted[DATA_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/long_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : long_divider_seq
// Description : Sequential radix-2 restoring divider, one quotient bit per
//               clock, MSB first, with valid/ready handshakes on both sides.
//               Accept edge loads the operands; DATA_W step cycles follow and
//               a final cycle registers the result, so o_valid rises DATA_W+1
//               edges after the accept edge (one edge for a zero divisor).
// Ports       : i_clk / i_reset (async, active-high)
//               i_valid, o_ready, i_dividend, i_divisor - operand handshake
//               o_valid, i_ready, o_quotient, o_remainder, o_div_by_zero -
//               result handshake
// Config      : define LONG_DIVIDER_SIGNED_EN for two's-complement operation
//               (quotient truncated toward zero, remainder takes the sign of
//               the dividend). Default build is unsigned only.
// Revision    : 1.0 - initial release
// ============================================================================
module long_divider_seq #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_div_by_zero
);

  import long_divider_pkg::*;

  localparam int              CNT_W      = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;   // partial remainder
  logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend in, quotient bits shift in
  logic [DATA_W-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rmd_q, rmd_d;
  logic              dbz_q, dbz_d;

  logic [DATA_W-1:0] w_dvd_load, w_dsr_load;
  logic [DATA_W-1:0] w_fin_quo, w_fin_rem, w_dbz_rem;
  logic [DATA_W-1:0] w_step_rem;
  logic              w_step_q;
  logic              w_accept;

  assign w_accept = (state_q == IDLE) && i_valid;

  long_divider_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DATA_W-1]),
    .divisor_i (dsr_q),
    .rem_o     (w_step_rem),
    .q_bit_o   (w_step_q)
  );

`ifdef LONG_DIVIDER_SIGNED_EN
  // Sign flags captured at accept; the core only ever sees magnitudes.
  logic neg_dvd_q, neg_dvd_d;
  logic neg_quo_q, neg_quo_d;

  assign w_dvd_load = i_dividend[DATA_W-1] ? -i_dividend : i_dividend;
  assign w_dsr_load = i_divisor[DATA_W-1]  ? -i_divisor  : i_divisor;
  // Most-negative / -1 yields magnitude 2^(DATA_W-1) with a positive sign,
  // which reads back as the most-negative value without special casing.
  assign w_fin_quo  = neg_quo_q ? -dvd_q : dvd_q;
  assign w_fin_rem  = neg_dvd_q ? -rem_q : rem_q;
  // On divide-by-zero dvd_q still holds the dividend magnitude untouched.
  assign w_dbz_rem  = neg_dvd_q ? -dvd_q : dvd_q;

  always_comb begin
    neg_dvd_d = neg_dvd_q;
    neg_quo_d = neg_quo_q;
    if (w_accept) begin
      neg_dvd_d = i_dividend[DATA_W-1];
      neg_quo_d = i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      neg_dvd_q <= 1'b0;
      neg_quo_q <= 1'b0;
    end else begin
      neg_dvd_q <= neg_dvd_d;
      neg_quo_q <= neg_quo_d;
    end
  end
`else
  assign w_dvd_load = i_dividend;
  assign w_dsr_load = i_divisor;
  assign w_fin_quo  = dvd_q;
  assign w_fin_rem  = rem_q;
  assign w_dbz_rem  = dvd_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = w_dvd_load;
          dsr_d   = w_dsr_load;
        end
      end

      CALC: begin
        if ((cnt_q == '0) && (dsr_q == '0)) begin
          // Zero divisor: no steps, report on the first CALC edge.
          state_d = DONE;
          quo_d   = c_div0_quotient[DATA_W-1:0];
          rmd_d   = w_dbz_rem;
          dbz_d   = 1'b1;
        end else if (cnt_q == c_last_cnt) begin
          state_d = DONE;
          quo_d   = w_fin_quo;
          rmd_d   = w_fin_rem;
          dbz_d   = 1'b0;
        end else begin
          rem_d = w_step_rem;
          dvd_d = {dvd_q[DATA_W-2:0], w_step_q};
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_ready       = (state_q == IDLE);
  assign o_valid       = (state_q == DONE);
  assign o_quotient    = quo_q;
  assign o_remainder   = rmd_q;
  assign o_div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_long_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_long_divider_seq
// Description : Self-checking bench for long_divider_seq (DATA_W=8). Directed
//               cases, reset abort, random operands and back-to-back traffic,
//               all checked against an arithmetic reference model.
//               Signed cases are included when LONG_DIVIDER_SIGNED_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_long_divider_seq;

  localparam int DATA_W = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_dividend;
  logic [DATA_W-1:0] i_divisor;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_quotient;
  logic [DATA_W-1:0] o_remainder;
  logic              o_div_by_zero;

  int n_asserts = 0;
  int n_fail    = 0;

  long_divider_seq #(
    .DATA_W (DATA_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: plain integer division.
  task automatic model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] r,
                       output logic f);
    int sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      f = 1'b1;
    end else begin
`ifdef LONG_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = DATA_W'(sa / sb);
      r  = DATA_W'(sa % sb);
`else
      sa = int'(a);
      sb = int'(b);
      q  = DATA_W'(sa / sb);
      r  = DATA_W'(sa % sb);
`endif
      f = 1'b0;
    end
  endtask

  task automatic run_div(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int hold, input string tag);
    logic [DATA_W-1:0] eq, er;
    logic              ef;
    int                cyc;
    model(a, b, eq, er, ef);
    chk({tag, " ready before"}, 32'(o_ready), 32'd1);
    i_dividend = a;
    i_divisor  = b;
    i_valid    = 1'b1;
    i_ready    = 1'b0;
    tick();
    i_valid    = 1'b0;
    i_dividend = DATA_W'($urandom);
    i_divisor  = DATA_W'($urandom);
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), (b == '0) ? 32'd1 : 32'(DATA_W + 1));
    chk({tag, " quotient"}, 32'(o_quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(o_remainder), 32'(er));
    chk({tag, " dbz"}, 32'(o_div_by_zero), 32'(ef));
    chk({tag, " ready in done"}, 32'(o_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'b1;  // must be ignored outside IDLE
      tick();
      chk({tag, " hold valid"}, 32'(o_valid), 32'd1);
      chk({tag, " hold quotient"}, 32'(o_quotient), 32'(eq));
      chk({tag, " hold remainder"}, 32'(o_remainder), 32'(er));
      chk({tag, " hold dbz"}, 32'(o_div_by_zero), 32'(ef));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, " valid after hs"}, 32'(o_valid), 32'd0);
    chk({tag, " ready after hs"}, 32'(o_ready), 32'd1);
    chk({tag, " dbz cleared"}, 32'(o_div_by_zero), 32'd0);
    chk({tag, " quotient kept"}, 32'(o_quotient), 32'(eq));
    chk({tag, " remainder kept"}, 32'(o_remainder), 32'(er));
  endtask

  initial begin
    logic [DATA_W-1:0] a, b, eq, er;
    logic              ef;
    logic              seen;
    int                acc, res, overlap;
    logic [DATA_W-1:0] q_q[$], q_r[$];
    logic              q_f[$];

    i_reset    = 1'b1;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    tick();
    tick();
    chk("reset ready", 32'(o_ready), 32'd1);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset quotient", 32'(o_quotient), 32'd0);
    chk("reset remainder", 32'(o_remainder), 32'd0);
    chk("reset dbz", 32'(o_div_by_zero), 32'd0);
    i_reset = 1'b0;
    tick();

    run_div(8'd100, 8'd7, 0, "100/7");
    run_div(8'd37, 8'd0, 2, "37/0");
    run_div(8'd200, 8'd3, 5, "200/3");
`ifdef LONG_DIVIDER_SIGNED_EN
    run_div(8'hF9, 8'd2, 1, "-7/2");
    run_div(8'h80, 8'hFF, 1, "-128/-1");
    run_div(8'hF9, 8'd0, 1, "-7/0");
`endif

    // Reset in the middle of a division must discard it.
    i_dividend = 8'd255;
    i_divisor  = 8'd1;
    i_valid    = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (3) tick();
    i_reset = 1'b1;
    #1;
    chk("abort ready", 32'(o_ready), 32'd1);
    chk("abort valid", 32'(o_valid), 32'd0);
    chk("abort quotient", 32'(o_quotient), 32'd0);
    chk("abort remainder", 32'(o_remainder), 32'd0);
    tick();
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    chk("abort no valid", 32'(seen), 32'd0);
    chk("abort quotient later", 32'(o_quotient), 32'd0);
    run_div(8'd9, 8'd3, 0, "9/3");

    // Random operands, about one in eight with a zero divisor.
    for (int k = 0; k < 20; k++) begin
      a = DATA_W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
      run_div(a, b, int'($urandom_range(0, 2)), "random");
    end

    // Back-to-back: i_valid and i_ready held high.
    acc     = 0;
    res     = 0;
    overlap = 0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int c = 0; c < 160; c++) begin
      if (c == 130) i_valid = 1'b0;
      if (o_ready === 1'b1 && o_valid === 1'b1) overlap++;
      if (o_valid === 1'b1) begin
        res++;
        if (q_q.size() > 0) begin
          chk("b2b quotient", 32'(o_quotient), 32'(q_q.pop_front()));
          chk("b2b remainder", 32'(o_remainder), 32'(q_r.pop_front()));
          chk("b2b dbz", 32'(o_div_by_zero), 32'(q_f.pop_front()));
        end else begin
          chk("b2b unexpected result", 32'd1, 32'd0);
        end
      end
      a = DATA_W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : DATA_W'($urandom);
      i_dividend = a;
      i_divisor  = b;
      if (o_ready === 1'b1 && i_valid) begin
        acc++;
        model(a, b, eq, er, ef);
        q_q.push_back(eq);
        q_r.push_back(er);
        q_f.push_back(ef);
      end
      tick();
    end
    i_ready = 1'b0;
    chk("b2b ready+valid overlap", 32'(overlap), 32'd0);
    chk("b2b pending results", 32'(q_q.size()), 32'd0);
    chk("b2b accepts equal results", 32'(acc), 32'(res));
    chk("b2b enough traffic", 32'(acc >= 8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
